// File: rtl/fv_pkg.sv
// -----------------------------------------------------------------------------
// fv_pkg
// Shared feature-vector memory definitions:
//   Num_Banks_FV        number of FV memory banks (power of two)
//   FV_info_bank_width  full FV address width; the upper log2(Num_Banks_FV)
//                       bits select the bank, the rest is the in-bank address
//   FV_MEM_CNTL2FV_Bank_CNTL  per-bank command {valid, PE_tag, FV_Bank_addr}
// -----------------------------------------------------------------------------
package fv_pkg;

   localparam int Num_Banks_FV       = 4;
   localparam int FV_info_bank_width = 12;
   localparam int FV_PE_TAG_W        = 4;
   localparam int FV_BANK_SEL_W      = $clog2(Num_Banks_FV);
   localparam int FV_BANK_ADDR_W     = FV_info_bank_width - FV_BANK_SEL_W;

   typedef struct packed {
      logic                      valid;
      logic [FV_PE_TAG_W-1:0]    PE_tag;
      logic [FV_BANK_ADDR_W-1:0] FV_Bank_addr;
   } FV_MEM_CNTL2FV_Bank_CNTL;

   // Build a valid bank command from a winning requester's tag and bank address.
   function automatic FV_MEM_CNTL2FV_Bank_CNTL fv_make_cmd(
      input logic [FV_PE_TAG_W-1:0]    tag,
      input logic [FV_BANK_ADDR_W-1:0] bank_addr
   );
      FV_MEM_CNTL2FV_Bank_CNTL cmd;
      cmd.valid        = 1'b1;
      cmd.PE_tag       = tag;
      cmd.FV_Bank_addr = bank_addr;
      return cmd;
   endfunction

endpackage

// File: rtl/fv_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// fv_bank_arbiter_if
// Request handshake between the FV request FIFOs and the bank arbiter.
//   req_valid  [NUM_REQ]         requester i holds a request
//   req_addr   [NUM_REQ][ADDR_W] full FV address per requester
//   req_tag    [NUM_REQ][TAG_W]  PE tag per requester
//   req_ready  [NUM_REQ]         grant; transfer when valid & ready
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fv_bank_arbiter_if
   import fv_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = FV_info_bank_width,
   parameter int TAG_W   = FV_PE_TAG_W
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
   logic [NUM_REQ-1:0]             req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_tag,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_tag,
      output req_ready
   );

endinterface

// File: rtl/fv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fv_rr_arbiter
// Single-bank round-robin arbiter. Picks the first candidate at or above the
// priority pointer (wrapping) and moves the pointer just past the winner.
//   clk, reset    clock, asynchronous active-low reset
//   cand [N]      requesters currently asking for this bank
//   eligible      bank can accept a command this cycle
//   grant [N]     one-hot grant (all zero when no grant)
//   winner        index of the granted requester
//   grant_valid   a grant is issued this cycle
// -----------------------------------------------------------------------------
module fv_rr_arbiter
   import fv_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         cand,
   input  logic                 eligible,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] winner,
   output logic                 grant_valid
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] rr_ptr_r;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;
   logic             hit_s;

   // Wrapping search from the pointer; the first hit wins and later hits are masked.
   always_comb begin
      found_s = 1'b0;
      hit_s   = 1'b0;
      idx_s   = {IDX_W{1'b0}};
      winner  = {IDX_W{1'b0}};
      for (int k = 0; k < N; k++) begin
         idx_s   = rr_ptr_r + IDX_W'(k);
         hit_s   = ~found_s & cand[idx_s];
         winner  = hit_s ? idx_s : winner;
         found_s = found_s | hit_s;
      end
      grant_valid   = eligible & found_s;
      grant         = {N{1'b0}};
      grant[winner] = grant_valid;
   end

   // Priority pointer: moves to winner+1 on a grant (natural wrap), else holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_r <= {IDX_W{1'b0}};
      end else if (grant_valid) begin
         rr_ptr_r <= winner + 1'b1;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/fv_bank_arbiter.sv
// -----------------------------------------------------------------------------
// fv_bank_arbiter
// Shares the FV memory banks between independent FV request sources. Each bank
// has its own round-robin arbiter; the winner gets a combinational req_ready
// and, one cycle later, a registered one-cycle command on its bank.
//   clk                          clock, all state on rising edge
//   reset                        asynchronous active-low reset
//   req_if (slave)               req_valid / req_addr / req_tag / req_ready
//   Bank_busy [NUM_BANKS]        bank controller busy
//   FV_MEM_CNTL2FV_Bank_CNTL_out per-bank {valid, PE_tag, FV_Bank_addr}
// TAG_W and ADDR_W are expected to match the widths in fv_pkg.
// -----------------------------------------------------------------------------
module fv_bank_arbiter
   import fv_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_BANKS = Num_Banks_FV,
   parameter int ADDR_W    = FV_info_bank_width,
   parameter int TAG_W     = FV_PE_TAG_W
) (
   input  logic                                    clk,
   input  logic                                    reset,
   fv_bank_arbiter_if.slave                        req_if,
   input  logic [NUM_BANKS-1:0]                    Bank_busy,
   output FV_MEM_CNTL2FV_Bank_CNTL [NUM_BANKS-1:0] FV_MEM_CNTL2FV_Bank_CNTL_out
);

   localparam int SEL_W     = $clog2(NUM_BANKS);
   localparam int REQ_IDX_W = $clog2(NUM_REQ);
   localparam int BADDR_W   = ADDR_W - SEL_W;

   logic [NUM_BANKS-1:0][NUM_REQ-1:0]   cand_s;
   logic [NUM_BANKS-1:0][NUM_REQ-1:0]   grant_s;
   logic [NUM_BANKS-1:0][REQ_IDX_W-1:0] winner_s;
   logic [NUM_BANKS-1:0]                grant_valid_s;
   logic [NUM_BANKS-1:0]                eligible_s;
   logic [NUM_REQ-1:0]                  ready_s;
   FV_MEM_CNTL2FV_Bank_CNTL [NUM_BANKS-1:0] out_r;

   // Bank decode and eligibility. A bank whose command register is still valid
   // is skipped: its busy flag only rises one cycle after it accepts.
   always_comb begin
      cand_s     = {(NUM_BANKS*NUM_REQ){1'b0}};
      eligible_s = {NUM_BANKS{1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) begin
         eligible_s[b] = ~Bank_busy[b] & ~out_r[b].valid;
         for (int i = 0; i < NUM_REQ; i++) begin
            cand_s[b][i] = req_if.req_valid[i] &
                           (req_if.req_addr[i][ADDR_W-1 -: SEL_W] == SEL_W'(b));
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      fv_rr_arbiter #(
         .N(NUM_REQ)
      ) u_arb (
         .clk        (clk),
         .reset      (reset),
         .cand       (cand_s[b]),
         .eligible   (eligible_s[b]),
         .grant      (grant_s[b]),
         .winner     (winner_s[b]),
         .grant_valid(grant_valid_s[b])
      );
   end

   // Merge per-bank grants onto req_ready. A requester addresses a single bank,
   // so at most one bank can grant it. Held low while reset is asserted.
   always_comb begin
      ready_s = {NUM_REQ{1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) begin
         ready_s = ready_s | grant_s[b];
      end
      if (reset) begin
         req_if.req_ready = ready_s;
      end else begin
         req_if.req_ready = {NUM_REQ{1'b0}};
      end
   end

   // Command registers: one-cycle valid per grant; tag/address hold otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_r <= {($bits(FV_MEM_CNTL2FV_Bank_CNTL)*NUM_BANKS){1'b0}};
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_valid_s[b]) begin
               out_r[b] <= fv_make_cmd(req_if.req_tag[winner_s[b]],
                                       req_if.req_addr[winner_s[b]][BADDR_W-1:0]);
            end else begin
               out_r[b].valid <= 1'b0;
            end
         end
      end
   end

   assign FV_MEM_CNTL2FV_Bank_CNTL_out = out_r;

endmodule

// File: tb/tb_fv_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fv_bank_arbiter
// Self-checking bench: directed sequences, a vector table and random traffic,
// all compared against a behavioural bank/round-robin model.
// -----------------------------------------------------------------------------
module tb_fv_bank_arbiter;
   import fv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic [3:0] Bank_busy;
   FV_MEM_CNTL2FV_Bank_CNTL [3:0] fv_out;

   fv_bank_arbiter_if #(.NUM_REQ(4), .ADDR_W(12), .TAG_W(4)) bus ();

   fv_bank_arbiter #(
      .NUM_REQ(4), .NUM_BANKS(4), .ADDR_W(12), .TAG_W(4)
   ) dut (
      .clk                         (clk),
      .reset                       (reset),
      .req_if                      (bus),
      .Bank_busy                   (Bank_busy),
      .FV_MEM_CNTL2FV_Bank_CNTL_out(fv_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [3:0] rdy_seen;

   // reference model state per bank
   int         m_ptr [4];
   bit         m_val [4];
   logic [3:0] m_tag [4];
   logic [9:0] m_low [4];

   typedef struct {
      logic [3:0] valid;
      logic [7:0] banks;    // 2 bits per requester, req0 in the LSBs
      logic [3:0] busy;
      logic [3:0] exp_rdy;
      logic [3:0] exp_oval;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         m_ptr[b] = 0; m_val[b] = 0; m_tag[b] = 4'd0; m_low[b] = 10'd0;
      end
   endtask

   task automatic req(input int i, input logic v, input logic [1:0] bank,
                      input logic [9:0] low, input logic [3:0] tag);
      bus.req_valid[i] = v;
      bus.req_addr[i]  = {bank, low};
      bus.req_tag[i]   = tag;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < 4; i++) req(i, 1'b0, 2'd0, 10'd0, 4'd0);
   endtask

   function automatic logic [3:0] ovals();
      logic [3:0] v;
      for (int b = 0; b < 4; b++) v[b] = fv_out[b].valid;
      return v;
   endfunction

   // One clock: check ready mid-cycle, advance, check bank commands against model.
   task automatic step(input string name);
      int win [4];
      logic [3:0]  exp_rdy;
      logic [63:0] exp_out;
      @(negedge clk);
      exp_rdy = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         win[b] = -1;
         if (!Bank_busy[b] && !m_val[b]) begin
            for (int k = 0; k < 4; k++) begin
               int i;
               i = (m_ptr[b] + k) % 4;
               if (win[b] < 0 && bus.req_valid[i] && (bus.req_addr[i] >> 10) == b) win[b] = i;
            end
         end
         if (win[b] >= 0) exp_rdy[win[b]] = 1'b1;
      end
      rdy_seen = bus.req_ready;
      check({name, " ready"}, 64'(rdy_seen), 64'(exp_rdy));
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
         if (win[b] >= 0) begin
            m_val[b] = 1;
            m_tag[b] = bus.req_tag[win[b]];
            m_low[b] = bus.req_addr[win[b]][9:0];
            m_ptr[b] = (win[b] + 1) % 4;
         end else begin
            m_val[b] = 0;
         end
      end
      #1;
      exp_out = 64'd0;
      for (int b = 0; b < 4; b++) exp_out[b*15 +: 15] = {m_val[b], m_tag[b], m_low[b]};
      check({name, " out"}, 64'(fv_out), exp_out);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      clear_reqs();
      Bank_busy = 4'b0000;
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic new_req(input int i);
      req(i, 1'b1, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
          4'($urandom_range(0, 15)));
   endtask

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b0;
      Bank_busy = 4'b0000;
      for (int i = 0; i < 4; i++) req(i, 1'b1, 2'(i), 10'd3, 4'd1);
      model_reset();
      #3;
      check("reset ready", 64'(bus.req_ready), 64'd0);
      check("reset out", 64'(fv_out), 64'd0);
      @(posedge clk);
      #1;
      check("reset out edge", 64'(fv_out), 64'd0);
      reset = 1'b1;
      clear_reqs();

      // ---------------- single request ----------------
      req(0, 1'b1, 2'd2, 10'h155, 4'd5);
      step("single");
      check("single ready", 64'(rdy_seen), 64'h1);
      check("single out2", 64'(fv_out[2]), 64'({1'b1, 4'd5, 10'h155}));
      check("single ovals", 64'(ovals()), 64'h4);
      clear_reqs();
      step("single idle");

      // ---------------- contention on bank 1 ----------------
      for (int i = 0; i < 4; i++) req(i, 1'b1, 2'd1, 10'(16 * i), 4'(i + 8));
      for (int c = 0; c < 9; c++) begin
         step("contend");
         if (c % 2 == 0) check("contend order", 64'(rdy_seen), 64'(4'b0001 << ((c / 2) % 4)));
         else check("contend gap", 64'(rdy_seen), 64'd0);
      end
      clear_reqs();
      step("contend idle");

      // ---------------- parallel banks ----------------
      for (int i = 0; i < 4; i++) req(i, 1'b1, 2'(i), 10'(100 + i), 4'(i));
      step("parallel");
      check("parallel ready", 64'(rdy_seen), 64'hF);
      check("parallel ovals", 64'(ovals()), 64'hF);
      clear_reqs();
      step("parallel idle");

      // ---------------- busy stall on bank 3 ----------------
      Bank_busy = 4'b1000;
      req(2, 1'b1, 2'd3, 10'h2AA, 4'd9);
      for (int c = 0; c < 5; c++) begin
         step("busy");
         check("busy no grant", 64'(rdy_seen), 64'd0);
      end
      Bank_busy = 4'b0000;
      step("busy release");
      check("busy release ready", 64'(rdy_seen), 64'h4);
      check("busy release out3", 64'(fv_out[3]), 64'({1'b1, 4'd9, 10'h2AA}));
      clear_reqs();
      step("busy idle");

      // ---------------- re-issue block on bank 0 ----------------
      // bank 0 pointer sits at 1 after the parallel test, so req1 goes first
      req(0, 1'b1, 2'd0, 10'd7, 4'd2);
      req(1, 1'b1, 2'd0, 10'd8, 4'd3);
      step("reissue t");
      check("reissue t ready", 64'(rdy_seen), 64'h2);
      req(1, 1'b0, 2'd0, 10'd8, 4'd3);
      step("reissue t1");
      check("reissue t1 ready", 64'(rdy_seen), 64'd0);
      step("reissue t2");
      check("reissue t2 ready", 64'(rdy_seen), 64'h1);
      clear_reqs();
      step("reissue idle");

      // ---------------- asynchronous reset mid-operation ----------------
      req(1, 1'b1, 2'd1, 10'd21, 4'd6);
      step("midreset setup");
      check("midreset out1 valid", 64'(fv_out[1].valid), 64'd1);
      req(3, 1'b1, 2'd0, 10'd22, 4'd7);
      #2 reset = 1'b0;
      #1;
      check("midreset out", 64'(fv_out), 64'd0);
      check("midreset ready", 64'(bus.req_ready), 64'd0);
      model_reset();
      clear_reqs();
      @(posedge clk);
      #1 reset = 1'b1;
      req(1, 1'b1, 2'd1, 10'd30, 4'd1);
      req(3, 1'b1, 2'd1, 10'd31, 4'd3);
      step("after reset");
      check("after reset first", 64'(rdy_seen), 64'h2);
      req(1, 1'b0, 2'd1, 10'd30, 4'd1);
      step("after reset gap");
      check("after reset gap", 64'(rdy_seen), 64'd0);
      step("after reset second");
      check("after reset second", 64'(rdy_seen), 64'h8);
      clear_reqs();
      step("after reset idle");

      // ---------------- vector table ----------------
      tbl[0]  = '{4'b1111, 8'b01_01_00_00, 4'b0000, 4'b0101, 4'b0011};
      tbl[1]  = '{4'b1111, 8'b01_01_00_00, 4'b0000, 4'b0000, 4'b0000};
      tbl[2]  = '{4'b1111, 8'b01_01_00_00, 4'b0000, 4'b1010, 4'b0011};
      tbl[3]  = '{4'b1111, 8'b10_10_10_10, 4'b0100, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b1111, 8'b10_10_10_10, 4'b0000, 4'b0001, 4'b0100};
      tbl[5]  = '{4'b0110, 8'b00_11_10_00, 4'b0000, 4'b0100, 4'b1000};
      tbl[6]  = '{4'b0010, 8'b00_00_10_00, 4'b0000, 4'b0010, 4'b0100};
      tbl[7]  = '{4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000};
      tbl[8]  = '{4'b1001, 8'b11_00_00_11, 4'b1000, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b1001, 8'b11_00_00_11, 4'b0000, 4'b1000, 4'b1000};
      tbl[10] = '{4'b0001, 8'b11_00_00_11, 4'b0000, 4'b0000, 4'b0000};
      tbl[11] = '{4'b0001, 8'b11_00_00_11, 4'b0000, 4'b0001, 4'b1000};
      pulse_reset();
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 4; i++)
            req(i, tbl[r].valid[i], tbl[r].banks[2*i +: 2], 10'(i * 37), 4'(i + 3));
         Bank_busy = tbl[r].busy;
         step("tbl");
         check("tbl ready", 64'(rdy_seen), 64'(tbl[r].exp_rdy));
         check("tbl ovals", 64'(ovals()), 64'(tbl[r].exp_oval));
      end

      // ---------------- random traffic ----------------
      pulse_reset();
      for (int c = 0; c < 400; c++) begin
         step("rand");
         for (int i = 0; i < 4; i++) begin
            if (bus.req_valid[i] && rdy_seen[i]) begin
               if ($urandom_range(0, 1) == 1) new_req(i);
               else bus.req_valid[i] = 1'b0;
            end else if (bus.req_valid[i]) begin
               if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
         for (int b = 0; b < 4; b++) Bank_busy[b] = ($urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
